// File: rtl/sdf_delay_line_pkg.sv
// Shared FFT datapath definitions for the SDF delay line: default sample
// width, complex sample layout and control-state encoding.
package sdf_delay_line_pkg;

  localparam int DW_DEFAULT = 24;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sdf_state_e;

endpackage

// File: rtl/sdf_stage_reg.sv
// One complex delay stage with its valid bit. It loads its neighbour's
// contents on advance and clears on flush.
module sdf_stage_reg
  import sdf_delay_line_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          vld,
  output logic [DW-1:0] re,
  output logic [DW-1:0] im
);

  // NOTE: the data is reset as well as the valid bit, so dout reads 0 after reset, exactly like a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      re  <= '0;
      im  <= '0;
    end else if (flush) begin
      vld <= 1'b0;
      re  <= '0;
      im  <= '0;
    end else if (advance) begin
      // NOTE: non-blocking, so every stage samples its neighbour's pre-edge value.
      vld <= in_vld;
      re  <= in_re;
      im  <= in_im;
    end
  end

endmodule

// File: rtl/sdf_delay_line.sv
// Configurable SDF feedback delay line. DEPTH shifting complex stages carry
// valid bits, so that input gaps travel as bubbles at a fixed latency.
module sdf_delay_line
  import sdf_delay_line_pkg::*;
#(
  parameter  int DW    = DW_DEFAULT,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic          flush,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i,
  output logic          out_valid,
  output logic          busy,
  output logic [CW-1:0] fill_cnt
);

  logic          vld_q [DEPTH];
  logic [DW-1:0] re_q  [DEPTH];
  logic [DW-1:0] im_q  [DEPTH];

  logic          any_valid;
  logic          advance;
  logic          leaving;
  logic [CW-1:0] fill_nxt;
  sdf_state_e    state, state_nxt;

  // NOTE: always_comb assigns a default before any branch, so no latch can be inferred.
  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) any_valid = any_valid | vld_q[k];
  end

  assign advance = in_valid | any_valid;
  assign leaving = vld_q[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic          vi;
    logic [DW-1:0] ri, ii;
    if (g == 0) begin : g_head
      // Without a sample, the input stage loads a zero bubble.
      assign vi = in_valid;
      assign ri = in_valid ? din_r : '0;
      assign ii = in_valid ? din_i : '0;
    end else begin : g_link
      assign vi = vld_q[g-1];
      assign ri = re_q[g-1];
      assign ii = im_q[g-1];
    end
    sdf_stage_reg #(.DW(DW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (advance),
      .flush   (flush),
      .in_vld  (vi),
      .in_re   (ri),
      .in_im   (ii),
      .vld     (vld_q[g]),
      .re      (re_q[g]),
      .im      (im_q[g])
    );
  end

  assign dout_r    = re_q[DEPTH-1];
  assign dout_i    = im_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];
  assign busy      = (state != IDLE);

  // The state follows the line's occupancy after the edge: an empty line ends the drain.
  always_comb begin
    fill_nxt = fill_cnt;
    if (in_valid && !leaving)      fill_nxt = fill_cnt + CW'(1);
    else if (!in_valid && leaving) fill_nxt = fill_cnt - CW'(1);

    state_nxt = state;
    if (in_valid)              state_nxt = RUN;
    else if (fill_nxt == '0)   state_nxt = IDLE;
    else if (state != IDLE)    state_nxt = DRAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else if (flush) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

endmodule

// File: tb/tb_sdf_delay_line.sv
// Directed bench for sdf_delay_line: a DEPTH=4 instance driven from a vector
// table plus hand sequences, and a DEPTH=1 instance for the sign-edge values.
module tb_sdf_delay_line;

  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic          in_valid4, flush4;
  logic [DW-1:0] din_r4, din_i4, dout_r4, dout_i4;
  logic          out_valid4, busy4;
  logic [2:0]    fill_cnt4;

  // DEPTH=1 instance
  logic          in_valid1, flush1;
  logic [DW-1:0] din_r1, din_i1, dout_r1, dout_i1;
  logic          out_valid1, busy1;
  logic [0:0]    fill_cnt1;

  sdf_delay_line #(.DW(DW), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .din_r(din_r4), .din_i(din_i4),
    .flush(flush4), .dout_r(dout_r4), .dout_i(dout_i4), .out_valid(out_valid4),
    .busy(busy4), .fill_cnt(fill_cnt4)
  );

  sdf_delay_line #(.DW(DW), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .din_r(din_r1), .din_i(din_i1),
    .flush(flush1), .dout_r(dout_r1), .dout_i(dout_i1), .out_valid(out_valid1),
    .busy(busy1), .fill_cnt(fill_cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge, and outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic          fl;
    logic [DW-1:0] r, i;
    logic          ov;
    logic [DW-1:0] er, ei;
    logic          bsy;
    logic [2:0]    fill;
  } vec_t;

  function automatic vec_t mk(logic iv, logic fl, int r, int i, logic ov, int er, int ei,
                              logic bsy, int fill);
    vec_t v;
    v.iv = iv; v.fl = fl; v.r = DW'(r); v.i = DW'(i);
    v.ov = ov; v.er = DW'(er); v.ei = DW'(ei); v.bsy = bsy; v.fill = 3'(fill);
    return v;
  endfunction

  task automatic chk4(input string tag, input logic ov, input logic [DW-1:0] er,
                      input logic [DW-1:0] ei, input logic bsy, input logic [2:0] fill);
    check({tag, " out_valid"}, 64'(out_valid4), 64'(ov));
    check({tag, " dout_r"},    64'(dout_r4),    64'(er));
    check({tag, " dout_i"},    64'(dout_i4),    64'(ei));
    check({tag, " busy"},      64'(busy4),      64'(bsy));
    check({tag, " fill_cnt"},  64'(fill_cnt4),  64'(fill));
  endtask

  vec_t vecs [20];

  initial begin
    // Contiguous burst re=1..8, im=-1..-8; the first output appears after the 4th edge.
    vecs[0]  = mk(1, 0, 1, -1, 0, 0,  0, 1, 1);
    vecs[1]  = mk(1, 0, 2, -2, 0, 0,  0, 1, 2);
    vecs[2]  = mk(1, 0, 3, -3, 0, 0,  0, 1, 3);
    vecs[3]  = mk(1, 0, 4, -4, 1, 1, -1, 1, 4);
    vecs[4]  = mk(1, 0, 5, -5, 1, 2, -2, 1, 4);
    vecs[5]  = mk(1, 0, 6, -6, 1, 3, -3, 1, 4);
    vecs[6]  = mk(1, 0, 7, -7, 1, 4, -4, 1, 4);
    vecs[7]  = mk(1, 0, 8, -8, 1, 5, -5, 1, 4);
    vecs[8]  = mk(0, 0, 0,  0, 1, 6, -6, 1, 3);
    vecs[9]  = mk(0, 0, 0,  0, 1, 7, -7, 1, 2);
    vecs[10] = mk(0, 0, 0,  0, 1, 8, -8, 1, 1);
    vecs[11] = mk(0, 0, 0,  0, 0, 0,  0, 0, 0);
    // Samples 1, 2, a one-cycle gap, then 3: the bubble reaches dout between 2 and 3.
    vecs[12] = mk(1, 0, 1, -1, 0, 0,  0, 1, 1);
    vecs[13] = mk(1, 0, 2, -2, 0, 0,  0, 1, 2);
    vecs[14] = mk(0, 0, 0,  0, 0, 0,  0, 1, 2);
    vecs[15] = mk(1, 0, 3, -3, 1, 1, -1, 1, 3);
    vecs[16] = mk(0, 0, 0,  0, 1, 2, -2, 1, 2);
    vecs[17] = mk(0, 0, 0,  0, 0, 0,  0, 1, 1);
    vecs[18] = mk(0, 0, 0,  0, 1, 3, -3, 1, 1);
    vecs[19] = mk(0, 0, 0,  0, 0, 0,  0, 0, 0);

    in_valid1 = 1'b0; flush1 = 1'b0; din_r1 = '0; din_i1 = '0;
    flush4 = 1'b0;

    // Reset held while random inputs are driven: the outputs must stay cleared.
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid4 = 1'b1; din_r4 = DW'($urandom); din_i4 = DW'($urandom);
      in_valid1 = 1'b1; din_r1 = DW'($urandom); din_i1 = DW'($urandom);
      tick();
      chk4($sformatf("reset%0d", k), 0, 0, 0, 0, 0);
      check($sformatf("reset%0d d1 out_valid", k), 64'(out_valid1), 64'd0);
      check($sformatf("reset%0d d1 busy", k), 64'(busy1), 64'd0);
    end
    in_valid4 = 1'b0; din_r4 = '0; din_i4 = '0;
    in_valid1 = 1'b0; din_r1 = '0; din_i1 = '0;
    #3 rst_n = 1'b1;
    tick();
    chk4("post_reset idle", 0, 0, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      in_valid4 = vecs[k].iv; flush4 = vecs[k].fl;
      din_r4 = vecs[k].r;     din_i4 = vecs[k].i;
      tick();
      chk4($sformatf("vec%0d", k), vecs[k].ov, vecs[k].er, vecs[k].ei, vecs[k].bsy, vecs[k].fill);
    end
    in_valid4 = 1'b0; din_r4 = '0; din_i4 = '0;

    // Flush with in_valid after 3 samples: everything drops, and nothing ever reaches dout.
    for (int k = 1; k <= 3; k++) begin
      in_valid4 = 1'b1; din_r4 = DW'(10 + k); din_i4 = DW'(-(10 + k));
      tick();
      chk4($sformatf("flush_fill%0d", k), 0, 0, 0, 1, 3'(k));
    end
    in_valid4 = 1'b1; flush4 = 1'b1; din_r4 = DW'(14); din_i4 = DW'(-14);
    tick();
    chk4("flush_edge", 0, 0, 0, 0, 0);
    in_valid4 = 1'b0; flush4 = 1'b0; din_r4 = '0; din_i4 = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk4($sformatf("post_flush%0d", k), 0, 0, 0, 0, 0);
    end

    // Asynchronous reset between edges in mid-DRAIN, then a cold-start burst.
    for (int k = 1; k <= 4; k++) begin
      in_valid4 = 1'b1; din_r4 = DW'(20 + k); din_i4 = DW'(-(20 + k));
      tick();
    end
    in_valid4 = 1'b0; din_r4 = '0; din_i4 = '0;
    tick();
    chk4("drain_pre_reset", 1, DW'(22), DW'(-22), 1, 3);
    #3 rst_n = 1'b0;
    #1 chk4("async_reset", 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    in_valid4 = 1'b1; din_r4 = DW'(9); din_i4 = DW'(-9);
    tick();
    chk4("cold_burst e1", 0, 0, 0, 1, 1);
    in_valid4 = 1'b0; din_r4 = '0; din_i4 = '0;
    tick(); tick();
    chk4("cold_burst e3", 0, 0, 0, 1, 1);
    tick();
    chk4("cold_burst e4", 1, DW'(9), DW'(-9), 1, 1);
    tick();
    chk4("cold_burst e5", 0, 0, 0, 0, 0);

    // DEPTH=1 with the extreme two's-complement values: bit-exact after one edge.
    in_valid1 = 1'b1; din_r1 = 24'h800000; din_i1 = 24'h7FFFFF;
    tick();
    check("d1 s1 out_valid", 64'(out_valid1), 64'd1);
    check("d1 s1 dout_r", 64'(dout_r1), 64'h800000);
    check("d1 s1 dout_i", 64'(dout_i1), 64'h7FFFFF);
    check("d1 s1 sign_r", 64'($signed(dout_r1) < 0), 64'd1);
    check("d1 s1 busy", 64'(busy1), 64'd1);
    check("d1 s1 fill_cnt", 64'(fill_cnt1), 64'd1);
    din_r1 = 24'h7FFFFF; din_i1 = 24'h800000;
    tick();
    check("d1 s2 dout_r", 64'(dout_r1), 64'h7FFFFF);
    check("d1 s2 dout_i", 64'(dout_i1), 64'h800000);
    check("d1 s2 sign_i", 64'($signed(dout_i1) < 0), 64'd1);
    check("d1 s2 fill_cnt", 64'(fill_cnt1), 64'd1);
    in_valid1 = 1'b0; din_r1 = '0; din_i1 = '0;
    tick();
    check("d1 end out_valid", 64'(out_valid1), 64'd0);
    check("d1 end dout_r", 64'(dout_r1), 64'd0);
    check("d1 end busy", 64'(busy1), 64'd0);
    check("d1 end fill_cnt", 64'(fill_cnt1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
